matmul_nxn_seq_par: RTL and testbench
=====================================

Name: matmul_nxn_seq_par

Overview:
Parametrised sequential NxN matrix multiplier: C = A x B, or C = C + A x B in accumulate mode. LANES parallel MAC lanes each compute one output column of the current row group. Adds a busy/done/abort handshake, signed/unsigned mode, saturating or wrapping output, and a sticky saturation flag. Sits beside the single-MAC 8x8 multiplier as the configurable compute tile for the MiniGPU datapath.

Parameters:
N, 8, matrix dimension; N >= 2
DW, 8, input element width
OW, 16, output element width
ACC_W, 2*DW+$clog2(N), internal accumulator width; must be >= OW
LANES, 1, parallel MAC lanes; N % LANES == 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only when busy=0
abort  in  1  cancel current operation
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at start
sat_en  in  1  1 = clamp to OW range, 0 = truncate to low OW bits; sampled at start
acc_en  in  1  1 = accumulators preload from current C element, 0 = preload zero; sampled at start
A  in  N*N*DW  row-major, element (r,c) at [(r*N+c)*DW +: DW]
B  in  N*N*DW  row-major, same packing as A
C  out  N*N*OW  row-major result, element (r,c) at [(r*N+c)*OW +: OW]
busy  out  1  high from the cycle after start is accepted until DONE or abort
done  out  1  one-cycle pulse when all N*N results are written
sat_flag  out  1  sticky; set if any stored element clamped during the current operation

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: C=0, busy=0, done=0, sat_flag=0, state=IDLE, all counters 0. rst overrides everything, including mid-operation.
- At start acceptance: A, B and the three mode bits are latched into internal registers. The inputs may change freely afterwards. sat_flag is cleared.
- start while busy=1 is ignored.
- FSM states:
  - IDLE: on start -> LOAD.
  - LOAD (1 cycle): lanes preload 0, or sign-/zero-extended C(i, j0+l) when acc_en=1; k=0 -> ACCUM.
  - ACCUM (N cycles): lane l adds A(i,k)*B(k,j0+l); k increments; after k=N-1 -> STORE.
  - STORE (1 cycle): write all lanes to C; advance j0 by LANES; on wrap, j0=0 and i++. Last group (i=N-1, j0=N-LANES) -> DONE, otherwise -> LOAD.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: G=N*N/LANES groups of N+2 cycles each. done is high in cycle G*(N+2)+1 after the start edge. Default config: 641; LANES=4: 161. busy is high for exactly G*(N+2) cycles.
- Arithmetic:
  - Product is 2*DW wide, signed or unsigned per mode, extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
  - STORE with sat_en=1 clamps to [-2^(OW-1), 2^(OW-1)-1] in signed mode or [0, 2^OW-1] in unsigned mode, and sets sat_flag on any clamp. With sat_en=0 it stores the low OW bits and sat_flag is untouched.
- abort while busy: return to IDLE next cycle, busy=0, no done pulse. Already-stored C elements are kept and the rest are unchanged. abort while idle has no effect. abort together with start in IDLE: start is ignored.
- C is stable from DONE until the next accepted start.

Decomposition:
- Shared package matmul_pkg: FSM state encoding (IDLE, LOAD, ACCUM, STORE, DONE), clog2 helper, element-index pack/unpack constants.
- Sub-module pe_mac_lane (DW, ACC_W): preload, valid, signed_mode inputs; registered accumulator. Instantiated LANES times via generate.
- Saturation/truncation logic is a function in the package.

Test Plan:
- Identity, default params: A=I, B(r,c)=r*8+c, signed, sat_en=1 -> C=B; busy high 640 cycles; done high exactly at cycle 641; sat_flag=0.
- Signed extremes: all A=B=-128 -> each element 131072. With sat_en=1: C=32767 everywhere, sat_flag=1. With sat_en=0: C=0 everywhere (131072 mod 65536), sat_flag=0.
- Unsigned: all A=B=0xFF, signed_mode=0 -> sum 520200. With sat_en=1: 65535 everywhere. With sat_en=0: 61448 everywhere.
- Accumulate: run scenario 1, then start with acc_en=1, A=I, B=I -> C(r,c)=r*8+c+(r==c ? 1 : 0).
- Control: abort at cycle 100 -> busy=0 next cycle, no done, C rows beyond those already stored unchanged. start pulsed mid-run is ignored; a later start completes normally. rst at cycle 300 -> all outputs 0 next cycle.
- LANES=4, N=8 build: 20 random signed/unsigned runs vs reference model -> exact C match, done at cycle 161.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier: FSM encoding,
// sizing/index helpers and the output saturation/truncation function.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACCUM,
        ST_STORE,
        ST_DONE
    } state_t;

    function automatic int clog2_fn(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Row-major flat element index of (r, c) in an n x n matrix.
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // v arrives already extended to 64 bits according to sgn.
    function automatic logic [63:0] sat_trunc(input logic signed [63:0] v,
                                              input int ow,
                                              input logic sgn,
                                              input logic sat_en,
                                              output logic clamped);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clamped = 1'b0;
        sat_trunc = v;
        if (sgn) begin
            hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (ow - 1));
        end else begin
            hi = (64'sd1 <<< ow) - 64'sd1;
            lo = 64'sd0;
        end
        if (sat_en) begin
            if (v > hi) begin
                sat_trunc = hi;
                clamped = 1'b1;
            end else if (v < lo) begin
                sat_trunc = lo;
                clamped = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/matmul_nxn_seq_par_pe_mac_lane.sv
// One MAC lane: preloadable accumulator adding a signed or unsigned DW x DW
// product each valid cycle, wrapping modulo 2^ACC_W.
module pe_mac_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 19
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             preload,
    input  logic [ACC_W-1:0] preload_val,
    input  logic             valid,
    input  logic             signed_mode,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc
);
    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;
    logic        [ACC_W-1:0] prod_x;

    assign prod_s = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    assign prod_u = (2*DW)'(a) * (2*DW)'(b);
    assign prod_x = signed_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (preload) begin
            acc <= preload_val;
        end else if (valid) begin
            acc <= acc + prod_x;
        end
    end

endmodule

// File: rtl/matmul_nxn_seq_par.sv
// Sequential NxN matrix multiplier, C = A x B or C += A x B, with LANES
// parallel MAC lanes each producing one column of the current row group.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | lanes preload 0 or the current C element
//   ST_ACCUM | N cycles of multiply-accumulate over k
//   ST_STORE | write lanes to C, advance to the next column group / row
//   ST_DONE  | one-cycle done pulse
module matmul_nxn_seq_par
    import matmul_pkg::*;
#(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int OW    = 16,
    parameter int ACC_W = 2*DW + $clog2(N),
    parameter int LANES = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              signed_mode,
    input  logic              sat_en,
    input  logic              acc_en,
    input  logic [N*N*DW-1:0] A,
    input  logic [N*N*DW-1:0] B,
    output logic [N*N*OW-1:0] C,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);
    localparam int IW = clog2_fn(N);

    state_t            state, state_nx;
    logic [N*N*DW-1:0] a_r, b_r;
    logic [N*N*OW-1:0] c_r;
    logic              sgn_r, sat_r, acc_en_r, sat_flag_r;
    logic [IW-1:0]     i_r, j0_r, k_r;
    logic              start_ok, abort_ok, last_k, last_grp;

    logic [DW-1:0]     lane_a;
    logic [DW-1:0]     lane_b     [LANES];
    logic [ACC_W-1:0]  lane_pre   [LANES];
    logic [ACC_W-1:0]  lane_acc   [LANES];
    logic [OW-1:0]     store_val  [LANES];
    logic [LANES-1:0]  store_clamp;

    assign busy     = (state == ST_LOAD) || (state == ST_ACCUM) || (state == ST_STORE);
    assign done     = (state == ST_DONE);
    assign start_ok = start && !abort && !busy;
    assign abort_ok = abort && busy;
    assign last_k   = (k_r == IW'(N - 1));
    assign last_grp = (i_r == IW'(N - 1)) && (j0_r == IW'(N - LANES));
    assign C        = c_r;
    assign sat_flag = sat_flag_r;

    assign lane_a = a_r[elem_idx(int'(i_r), int'(k_r), N)*DW +: DW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [OW-1:0] c_cur;
        assign c_cur       = c_r[elem_idx(int'(i_r), int'(j0_r) + l, N)*OW +: OW];
        assign lane_pre[l] = !acc_en_r ? '0 :
                             sgn_r     ? ACC_W'(c_cur) : ACC_W'($unsigned(c_cur));
        assign lane_b[l]   = b_r[elem_idx(int'(k_r), int'(j0_r) + l, N)*DW +: DW];

        pe_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .preload     (state == ST_LOAD),
            .preload_val (lane_pre[l]),
            .valid       (state == ST_ACCUM),
            .signed_mode (sgn_r),
            .a           (lane_a),
            .b           (lane_b[l]),
            .acc         (lane_acc[l])
        );
    end

    always_comb begin
        store_clamp = '0;
        store_val   = '{default: '0};
        for (int l = 0; l < LANES; l++) begin
            store_val[l] = OW'(sat_trunc(sgn_r ? 64'($signed(lane_acc[l])) : 64'(lane_acc[l]),
                                         OW, sgn_r, sat_r, store_clamp[l]));
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_ACCUM;
            ST_ACCUM: if (last_k) state_nx = ST_STORE;
            ST_STORE: state_nx = last_grp ? ST_DONE : ST_LOAD;
            ST_DONE:  state_nx = start_ok ? ST_LOAD : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort_ok) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= '0;
            sgn_r      <= 1'b0;
            sat_r      <= 1'b0;
            acc_en_r   <= 1'b0;
            sat_flag_r <= 1'b0;
            i_r        <= '0;
            j0_r       <= '0;
            k_r        <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                a_r        <= A;
                b_r        <= B;
                sgn_r      <= signed_mode;
                sat_r      <= sat_en;
                acc_en_r   <= acc_en;
                sat_flag_r <= 1'b0;
                i_r        <= '0;
                j0_r       <= '0;
                k_r        <= '0;
            end
            if (state == ST_LOAD) k_r <= '0;
            if (state == ST_ACCUM) k_r <= last_k ? '0 : k_r + 1'b1;
            // An abort landing on a STORE cycle discards that group.
            if (state == ST_STORE && !abort_ok) begin
                for (int l = 0; l < LANES; l++) begin
                    c_r[elem_idx(int'(i_r), int'(j0_r) + l, N)*OW +: OW] <= store_val[l];
                end
                if (|store_clamp) sat_flag_r <= 1'b1;
                if (last_grp) begin
                    i_r  <= '0;
                    j0_r <= '0;
                end else if (j0_r == IW'(N - LANES)) begin
                    j0_r <= '0;
                    i_r  <= i_r + 1'b1;
                end else begin
                    j0_r <= j0_r + IW'(LANES);
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_nxn_seq_par.sv
// Directed checks of the 8x8 multiplier (LANES=1) plus random runs of a
// LANES=4 build against a straightforward integer reference model.
module tb_matmul_nxn_seq_par;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int MW = N*N*DW;
    localparam int CW = N*N*OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 0, abort = 0, signed_mode = 0, sat_en = 0, acc_en = 0;
    logic [MW-1:0] A = '0, B = '0;
    logic [CW-1:0] C;
    logic          busy, done, sat_flag;

    logic          start4 = 0, abort4 = 0, sm4 = 0, se4 = 0, ae4 = 0;
    logic [MW-1:0] A4 = '0, B4 = '0;
    logic [CW-1:0] C4;
    logic          busy4, done4, sat4;

    int errors = 0;
    int checks = 0;

    matmul_nxn_seq_par #(.N(N), .DW(DW), .OW(OW), .LANES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .signed_mode(signed_mode),
        .sat_en(sat_en), .acc_en(acc_en), .A(A), .B(B), .C(C),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    matmul_nxn_seq_par #(.N(N), .DW(DW), .OW(OW), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .signed_mode(sm4),
        .sat_en(se4), .acc_en(ae4), .A(A4), .B(B4), .C(C4),
        .busy(busy4), .done(done4), .sat_flag(sat4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        int e;
        checks++;
        assert (obs === exp) else begin
            errors++;
            e = 0;
            for (int i = N*N - 1; i >= 0; i--)
                if (obs[i*OW +: OW] !== exp[i*OW +: OW]) e = i;
            $error("FAIL %s elem %0d observed=%0h expected=%0h", tag, e,
                   obs[e*OW +: OW], exp[e*OW +: OW]);
        end
    endtask

    function automatic logic [MW-1:0] mat_fill(input int kind, input logic [DW-1:0] v);
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (kind)
                    0: m[(r*N+c)*DW +: DW] = (r == c) ? DW'(1) : DW'(0);
                    1: m[(r*N+c)*DW +: DW] = DW'(r*N + c);
                    default: m[(r*N+c)*DW +: DW] = v;
                endcase
        return m;
    endfunction

    function automatic logic [CW-1:0] res_fill(input int kind, input logic [OW-1:0] v, input int upto);
        logic [CW-1:0] m;
        for (int e = 0; e < N*N; e++) begin
            case (kind)
                1: m[e*OW +: OW] = OW'(e);
                2: m[e*OW +: OW] = OW'(e + (((e / N) == (e % N)) ? 1 : 0));
                3: m[e*OW +: OW] = (e < upto) ? OW'(e) : v;
                default: m[e*OW +: OW] = v;
            endcase
        end
        return m;
    endfunction

    function automatic logic [CW-1:0] ref_mm(input logic [MW-1:0] a_v, input logic [MW-1:0] b_v,
                                             input logic [CW-1:0] c_prev, input logic sm,
                                             input logic se, input logic ae, output logic flag);
        logic [CW-1:0] m;
        longint s, pa, pb, hi, lo;
        flag = 1'b0;
        m = '0;
        hi = sm ? 64'sd32767 : 64'sd65535;
        lo = sm ? -64'sd32768 : 64'sd0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = 0;
                if (ae) s = sm ? longint'($signed(c_prev[(r*N+c)*OW +: OW]))
                               : longint'(c_prev[(r*N+c)*OW +: OW]);
                for (int k = 0; k < N; k++) begin
                    pa = sm ? longint'($signed(a_v[(r*N+k)*DW +: DW])) : longint'(a_v[(r*N+k)*DW +: DW]);
                    pb = sm ? longint'($signed(b_v[(k*N+c)*DW +: DW])) : longint'(b_v[(k*N+c)*DW +: DW]);
                    s += pa * pb;
                end
                s = s & 64'sd524287;
                if (sm && s >= 64'sd262144) s -= 64'sd524288;
                if (se && s > hi) begin s = hi; flag = 1'b1; end
                else if (se && s < lo) begin s = lo; flag = 1'b1; end
                m[(r*N+c)*OW +: OW] = s[OW-1:0];
            end
        return m;
    endfunction

    // Cycle n is the n-th cycle after the edge that accepts start; outputs are
    // sampled at the negedge inside cycle n, injections are driven there too.
    task automatic run_op(input logic [MW-1:0] a_v, input logic [MW-1:0] b_v,
                          input logic sm, input logic se, input logic ae,
                          input int abort_at, input int start_at, input int rst_at,
                          output int done_cyc, output int busy_cnt);
        @(negedge clk);
        A = a_v; B = b_v; signed_mode = sm; sat_en = se; acc_en = ae; start = 1;
        @(negedge clk);
        start = 0; A = ~a_v; B = ~b_v;
        done_cyc = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 1000; n++) begin
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) done_cyc = n;
            if (n > 1 && !busy) break;
            abort = (n == abort_at);
            start = (n == start_at);
            rst   = (n == rst_at);
            if (n == start_at) A = '1;
            @(negedge clk);
        end
        abort = 0; start = 0; rst = 0;
    endtask

    task automatic run4(input logic [MW-1:0] a_v, input logic [MW-1:0] b_v,
                        input logic sm, input logic se, input logic ae, output int done_cyc);
        @(negedge clk);
        A4 = a_v; B4 = b_v; sm4 = sm; se4 = se; ae4 = ae; start4 = 1;
        @(negedge clk);
        start4 = 0;
        done_cyc = 0;
        for (int n = 1; n <= 400; n++) begin
            if (done4 && done_cyc == 0) done_cyc = n;
            if (n > 1 && !busy4) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, bc, dones;
        logic [MW-1:0] ra, rb;
        logic [CW-1:0] exp4;
        logic rsm, rse, rae, rflag;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_mat("reset_C", C, '0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_sat", 64'(sat_flag), 0);
        rst = 0;

        run_op(mat_fill(0, 0), mat_fill(1, 0), 1, 1, 0, 0, 0, 0, dc, bc);
        chk_mat("ident_C", C, res_fill(1, 0, 0));
        chk("ident_busy_cycles", 64'(bc), 640);
        chk("ident_done_cycle", 64'(dc), 641);
        chk("ident_sat", 64'(sat_flag), 0);

        run_op(mat_fill(0, 0), mat_fill(0, 0), 1, 1, 1, 0, 0, 0, dc, bc);
        chk_mat("accum_C", C, res_fill(2, 0, 0));
        chk("accum_done_cycle", 64'(dc), 641);

        run_op(mat_fill(2, 8'h80), mat_fill(2, 8'h80), 1, 1, 0, 0, 0, 0, dc, bc);
        chk_mat("sneg_sat_C", C, res_fill(0, 16'd32767, 0));
        chk("sneg_sat_flag", 64'(sat_flag), 1);

        run_op(mat_fill(2, 8'h80), mat_fill(2, 8'h80), 1, 0, 0, 0, 0, 0, dc, bc);
        chk_mat("sneg_wrap_C", C, res_fill(0, 16'd0, 0));
        chk("sneg_wrap_flag", 64'(sat_flag), 0);

        run_op(mat_fill(2, 8'hFF), mat_fill(2, 8'hFF), 0, 0, 0, 0, 0, 0, dc, bc);
        chk_mat("uns_wrap_C", C, res_fill(0, 16'd61448, 0));
        chk("uns_wrap_flag", 64'(sat_flag), 0);

        run_op(mat_fill(2, 8'hFF), mat_fill(2, 8'hFF), 0, 1, 0, 0, 0, 0, dc, bc);
        chk_mat("uns_sat_C", C, res_fill(0, 16'd65535, 0));
        chk("uns_sat_flag", 64'(sat_flag), 1);

        // Abort sampled at the end of cycle 100 (the STORE of element 9):
        // elements 0..8 were stored, element 9 onwards keep 65535.
        run_op(mat_fill(0, 0), mat_fill(1, 0), 1, 1, 0, 100, 0, 0, dc, bc);
        chk("abort_busy_cycles", 64'(bc), 100);
        chk("abort_no_done", 64'(dc), 0);
        chk_mat("abort_C", C, res_fill(3, 16'd65535, 9));
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        chk("abort_stays_idle", 64'(dones), 0);

        run_op(mat_fill(0, 0), mat_fill(1, 0), 1, 1, 0, 0, 50, 0, dc, bc);
        chk_mat("midstart_C", C, res_fill(1, 0, 0));
        chk("midstart_done_cycle", 64'(dc), 641);

        run_op(mat_fill(2, 8'h80), mat_fill(2, 8'h80), 1, 1, 0, 0, 0, 300, dc, bc);
        chk_mat("midrst_C", C, '0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_sat", 64'(sat_flag), 0);
        chk("midrst_no_done", 64'(dc), 0);

        exp4 = '0;
        for (int t = 0; t < 20; t++) begin
            for (int w = 0; w < MW/32; w++) begin
                ra[w*32 +: 32] = $urandom();
                rb[w*32 +: 32] = $urandom();
            end
            rsm = 1'($urandom_range(0, 1));
            rse = 1'($urandom_range(0, 1));
            rae = 1'($urandom_range(0, 1));
            exp4 = ref_mm(ra, rb, exp4, rsm, rse, rae, rflag);
            run4(ra, rb, rsm, rse, rae, dc);
            chk_mat($sformatf("l4_run%0d_C", t), C4, exp4);
            chk($sformatf("l4_run%0d_done_cycle", t), 64'(dc), 161);
            chk($sformatf("l4_run%0d_sat", t), 64'(sat4), 64'(rflag));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
